// File: rtl/apb_pkg.sv
// Shared APB completer definitions: FSM states, bus width, default base and response codes.
package apb_pkg;

    localparam int          APB_DATA_W     = 32;
    localparam logic [31:0] APB_BASE_ADDR  = 32'hA000;
    localparam logic        APB_RESP_OKAY   = 1'b0;
    localparam logic        APB_RESP_SLVERR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } apb_state_e;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB3 bus bundle between the requester (master) and a completer (slave).
interface apb_slave_regfile_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_addr_decode.sv
// Maps an APB byte address onto a word index within a register window; flags misses and misalignment.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                NUM_REGS  = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(APB_BASE_ADDR),
    parameter int                IDX_W     = $clog2(NUM_REGS)
) (
    input  logic [ADDR_W-1:0] paddr,
    output logic [IDX_W-1:0]  idx,
    output logic              err
);
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(NUM_REGS * 4);

    logic [ADDR_W-1:0] offset;

    // offset only meaningful when paddr >= BASE_ADDR; the below-base term covers the wrap
    assign offset = paddr - BASE_ADDR;
    assign idx    = offset[IDX_W+1:2];
    assign err    = (paddr < BASE_ADDR) || (offset >= SPAN) || (paddr[1:0] != 2'b00);
endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer with a bank of 32-bit R/W registers, programmable wait states and PSLVERR decode.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = APB_DATA_W,
    parameter int                NUM_REGS    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(APB_BASE_ADDR),
    parameter int                WAIT_CYCLES = 1
) (
    input  logic                          PCLK,
    input  logic                          PRESET_n,
    apb_slave_regfile_if.slave            apb,
    output logic [NUM_REGS*DATA_W-1:0]    regs_o,
    output logic                          wr_stb_o,
    output logic [$clog2(NUM_REGS)-1:0]   wr_idx_o
);
    localparam int IDX_W = $clog2(NUM_REGS);

    apb_state_e                         state, state_nxt;
    logic [3:0]                         cnt, cnt_nxt;
    logic [IDX_W-1:0]                   idx_q, dec_idx, idx_sel;
    logic                               err_q, dec_err, err_sel;
    logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q;
    logic [DATA_W-1:0]                  prdata_q, rdata;
    logic                               pready_q, pslverr_q;
    logic                               setup, ready_set, commit;

    apb_addr_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_dec (
        .paddr (apb.PADDR),
        .idx   (dec_idx),
        .err   (dec_err)
    );

    assign setup = apb.PSEL & ~apb.PENABLE;

    // With zero wait states READY is entered on the setup edge, before the decode is latched
    assign idx_sel = (state == ST_IDLE) ? dec_idx : idx_q;
    assign err_sel = (state == ST_IDLE) ? dec_err : err_q;
    assign rdata   = (err_sel || apb.PWRITE) ? '0 : regs_q[idx_sel];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready_set = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (setup) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = ST_READY;
                        ready_set = 1'b1;
                    end else begin
                        cnt_nxt   = 4'(WAIT_CYCLES - 1);
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!apb.PSEL) begin
                    state_nxt = ST_IDLE;
                end else if (apb.PENABLE) begin
                    if (cnt == 4'd0) begin
                        state_nxt = ST_READY;
                        ready_set = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
            end
            ST_READY: begin
                state_nxt = ST_IDLE;
                commit    = apb.PSEL & apb.PENABLE & apb.PWRITE & ~err_q;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            regs_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= APB_RESP_OKAY;
            wr_stb_o  <= 1'b0;
            wr_idx_o  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            if (state == ST_IDLE && setup) begin
                idx_q <= dec_idx;
                err_q <= dec_err;
            end
            pready_q  <= ready_set;
            pslverr_q <= ready_set ? err_sel : APB_RESP_OKAY;
            prdata_q  <= ready_set ? rdata : '0;
            wr_stb_o  <= commit;
            if (commit) begin
                regs_q[idx_q] <= apb.PWDATA;
                wr_idx_o      <= idx_q;
            end
        end
    end

    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign apb.PRDATA  = prdata_q;
    assign regs_o      = regs_q;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench: three completers (0/1/3 wait states) driven by randomized APB transfers.
module tb_apb_slave_regfile;
    localparam int          ND   = 3;
    localparam int          NR   = 16;
    localparam logic [31:0] BASE = 32'hA000;

    logic PCLK = 1'b0;
    logic PRESET_n = 1'b0;
    always #5 PCLK = ~PCLK;

    logic [ND-1:0]    psel, penable, pwrite, pready, pslverr, wr_stb;
    logic [31:0]      paddr [ND];
    logic [31:0]      pwdata[ND];
    logic [31:0]      prdata[ND];
    logic [NR*32-1:0] regs_w[ND];
    logic [3:0]       wr_idx[ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        apb_slave_regfile_if #(.ADDR_W(32), .DATA_W(32)) bus ();
        assign bus.PSEL    = psel[g];
        assign bus.PENABLE = penable[g];
        assign bus.PADDR   = paddr[g];
        assign bus.PWRITE  = pwrite[g];
        assign bus.PWDATA  = pwdata[g];
        assign pready[g]   = bus.PREADY;
        assign pslverr[g]  = bus.PSLVERR;
        assign prdata[g]   = bus.PRDATA;

        apb_slave_regfile #(
            .ADDR_W      (32),
            .DATA_W      (32),
            .NUM_REGS    (NR),
            .BASE_ADDR   (BASE),
            .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .PCLK     (PCLK),
            .PRESET_n (PRESET_n),
            .apb      (bus),
            .regs_o   (regs_w[g]),
            .wr_stb_o (wr_stb[g]),
            .wr_idx_o (wr_idx[g])
        );
    end

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        int          setup;
        int          lat;
    } rsp_t;

    typedef struct {
        int d;
        int idx;
        int at;
    } stb_t;

    rsp_t        rspq[$];
    stb_t        stbq[$];
    logic [31:0] mem[ND][NR];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic int wc_of(int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    function automatic bit ref_err(logic [31:0] a);
        return (a < BASE) || (a >= BASE + NR * 4) || (a % 4 != 0);
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, want);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < ND; d++)
            for (int r = 0; r < NR; r++) mem[d][r] = '0;
    endtask

    task automatic check_all_zero(string tag);
        for (int g = 0; g < ND; g++) begin
            check($sformatf("%s_pready%0d", tag, g), 32'(pready[g]), 0);
            check($sformatf("%s_pslverr%0d", tag, g), 32'(pslverr[g]), 0);
            check($sformatf("%s_prdata%0d", tag, g), prdata[g], 0);
            check($sformatf("%s_wrstb%0d", tag, g), 32'(wr_stb[g]), 0);
            check($sformatf("%s_wridx%0d", tag, g), 32'(wr_idx[g]), 0);
            for (int r = 0; r < NR; r++)
                check($sformatf("%s_reg%0d_%0d", tag, g, r), regs_w[g][r*32 +: 32], 0);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the completion (or abort) edge.
    task automatic xfer(int d, logic [31:0] a, bit w, logic [31:0] wd,
                        int abort_after = 0, bit rst_abort = 0);
        bit e   = ref_err(a);
        int idx = e ? 0 : int'((a - BASE) >> 2);
        int n;
        psel[d] = 1'b1; penable[d] = 1'b0;
        paddr[d] = a; pwrite[d] = w; pwdata[d] = wd;
        if (abort_after == 0) begin
            rspq.push_back('{d, (e || w) ? 32'h0 : mem[d][idx], e, cyc + 1, wc_of(d)});
            if (w && !e) stbq.push_back('{d, idx, cyc + 2 + wc_of(d)});
        end
        @(posedge PCLK); #1;
        penable[d] = 1'b1;
        if (abort_after == 0) begin
            n = 0;
            do begin @(negedge PCLK); n++; end while (!pready[d] && n < 40);
            check($sformatf("xfer_ready_d%0d_%h", d, a), 32'(pready[d]), 1);
            @(posedge PCLK); #1;
            if (w && !e) mem[d][idx] = wd;
            psel[d] = 1'b0; penable[d] = 1'b0;
        end else begin
            for (int k = 0; k < abort_after; k++) begin
                @(negedge PCLK);
                check($sformatf("abort_no_ready_d%0d", d), 32'(pready[d]), 0);
                @(posedge PCLK); #1;
            end
            if (rst_abort) begin
                PRESET_n = 1'b0;
                #1;
                check_all_zero("midreset");
                clear_model();
                @(posedge PCLK); #1;
                PRESET_n = 1'b1;
                psel[d] = 1'b0; penable[d] = 1'b0;
            end else begin
                psel[d] = 1'b0; penable[d] = 1'b0;
                @(posedge PCLK); #1;
            end
        end
    endtask

    // Monitor: pops an expectation whenever a completer presents PREADY or a write strobe
    always @(negedge PCLK) begin
        rsp_t e;
        stb_t s;
        if (PRESET_n) begin
            for (int g = 0; g < ND; g++) begin
                if (pready[g]) begin
                    if (rspq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_pready: dut %0d got PREADY=1, expected no transfer", g);
                    end else begin
                        e = rspq.pop_front();
                        check("rsp_dut", g, e.d);
                        check("rsp_prdata", prdata[g], e.rdata);
                        check("rsp_pslverr", 32'(pslverr[g]), 32'(e.err));
                        check("rsp_latency", cyc - e.setup, e.lat);
                    end
                end
                if (wr_stb[g]) begin
                    if (stbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_wr_stb: dut %0d got wr_stb_o=1, expected 0", g);
                    end else begin
                        s = stbq.pop_front();
                        check("stb_dut", g, s.d);
                        check("stb_idx", 32'(wr_idx[g]), s.idx);
                        check("stb_cycle", cyc, s.at);
                    end
                end
            end
        end
    end

    task automatic rand_xfers(int d, int num);
        logic [31:0] a;
        for (int i = 0; i < num; i++) begin
            a = BASE + $urandom_range(0, 19) * 4 - 8;
            if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
            xfer(d, a, 1'($urandom_range(0, 1)), $urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        psel = '0; penable = '0; pwrite = '0;
        for (int d = 0; d < ND; d++) begin paddr[d] = '0; pwdata[d] = '0; end
        clear_model();
        #12;
        check_all_zero("reset");
        @(posedge PCLK); #1;
        PRESET_n = 1'b1;
        @(posedge PCLK); #1;

        // one wait state: basic read, write/readback, error cases
        xfer(0, 32'hA000, 0, 0);
        xfer(0, 32'hA008, 1, 32'hDEADBEEF);
        xfer(0, 32'hA008, 0, 0);
        check("regs_o_reg2", regs_w[0][95:64], 32'hDEADBEEF);
        xfer(0, 32'hA040, 1, 32'h12345678);
        xfer(0, 32'hA005, 1, 32'h87654321);
        xfer(0, 32'h9FFC, 0, 0);
        xfer(0, 32'hA03C, 0, 0);
        xfer(0, 32'hA03C, 1, 32'h0BADF00D);
        xfer(0, 32'hA03C, 0, 0);
        rand_xfers(0, 40);

        // zero wait states: back-to-back
        xfer(1, 32'hA000, 1, 32'h11111111);
        xfer(1, 32'hA004, 1, 32'h22222222);
        xfer(1, 32'hA000, 0, 0);
        xfer(1, 32'hA004, 0, 0);
        rand_xfers(1, 30);

        // three wait states: abort, then reset mid-transfer
        xfer(2, 32'hA00C, 1, 32'h0000CAFE, 1);
        xfer(2, 32'hA00C, 0, 0);
        xfer(2, 32'hA00C, 1, 32'h00000055);
        xfer(2, 32'hA004, 1, 32'h00000077);
        rand_xfers(2, 10);
        xfer(2, 32'hA004, 1, 32'h00000005, 1, 1);
        xfer(2, 32'hA004, 0, 0);
        xfer(0, 32'hA008, 0, 0);
        rand_xfers(2, 10);

        repeat (4) @(posedge PCLK);
        #1;
        for (int g = 0; g < ND; g++)
            for (int r = 0; r < NR; r++)
                check($sformatf("final_reg%0d_%0d", g, r), regs_w[g][r*32 +: 32], mem[g][r]);
        check("rsp_queue_drained", rspq.size(), 0);
        check("stb_queue_drained", stbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
